// File: rtl/wb_arb_pkg.sv
// Shared constants for the Wishbone BRAM arbiter: FSM encoding and default sizing.
package wb_arb_pkg;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;

    localparam int NM_DEF      = 2;
    localparam int AW_DEF      = 8;
    localparam int DW_DEF      = 8;
    localparam int TIMEOUT_DEF = 255;

endpackage

// File: rtl/wb_rr_pick.sv
// Combinational round-robin picker: first requester searching upward (wrapping)
// from last_gi+1, returned as a one-hot grant.
module wb_rr_pick
    import wb_arb_pkg::*;
#(
    parameter int NM = NM_DEF,
    parameter int GW = $clog2(NM)
) (
    input  logic [NM-1:0] req,
    input  logic [GW-1:0] last_gi,
    output logic [NM-1:0] grant,
    output logic          valid
);

    logic found;
    int   idx;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = 0;
        for (int i = 1; i <= NM; i++) begin
            idx = (int'(last_gi) + i) % NM;
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

    assign valid = |req;

endmodule

// File: rtl/wb_bram_arbiter.sv
// Round-robin Wishbone B4 pipelined arbiter sharing one BRAM port between NM masters.
// Optional watchdog abort of hung bus cycles: define WB_ARB_TIMEOUT_EN.
module wb_bram_arbiter
    import wb_arb_pkg::*;
#(
    parameter int NM      = NM_DEF,
    parameter int AW      = AW_DEF,
    parameter int DW      = DW_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic               i_clk,
    input  logic               i_reset_n,
    input  logic [NM-1:0]      i_m_cyc,
    input  logic [NM-1:0]      i_m_stb,
    input  logic [NM-1:0]      i_m_we,
    input  logic [NM*AW-1:0]   i_m_addr,
    input  logic [NM*DW-1:0]   i_m_data,
    input  logic [NM*DW/8-1:0] i_m_sel,
    output logic [NM-1:0]      o_m_stall,
    output logic [NM-1:0]      o_m_ack,
    output logic [NM-1:0]      o_m_err,
    output logic [DW-1:0]      o_m_data,
    output logic               o_s_cyc,
    output logic               o_s_stb,
    output logic               o_s_we,
    output logic [AW-1:0]      o_s_addr,
    output logic [DW-1:0]      o_s_data,
    output logic [DW/8-1:0]    o_s_sel,
    input  logic               i_s_stall,
    input  logic               i_s_ack,
    input  logic               i_s_err,
    input  logic [DW-1:0]      i_s_data
);

    localparam int GW = $clog2(NM);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam int SW = DW / 8;

    logic [0:0]    state;
    logic [NM-1:0] g;
    logic [NM-1:0] pick;
    logic          pick_vld;
    logic [GW-1:0] gi;
    logic [GW-1:0] last_gi;
    logic [GW-1:0] pick_idx;
    logic [CW-1:0] outstanding;
    logic          granted;
    logic          s_resp;
    logic          accept;
    logic          release_g;
    logic          timeout_hit;

    wb_rr_pick #(.NM(NM), .GW(GW)) u_pick (
        .req     (i_m_cyc),
        .last_gi (last_gi),
        .grant   (pick),
        .valid   (pick_vld)
    );

    always_comb begin
        pick_idx = '0;
        for (int k = 0; k < NM; k++) begin
            if (pick[k]) pick_idx = GW'(k);
        end
    end

    assign granted   = (state == ST_GRANT);
    assign s_resp    = i_s_ack | i_s_err;
    assign accept    = o_s_stb & ~i_s_stall;
    assign release_g = granted & (~i_m_cyc[gi] | timeout_hit);

    // Grant is only taken from IDLE, so every hand-over costs one idle cycle.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state   <= ST_IDLE;
            g       <= '0;
            gi      <= '0;
            last_gi <= GW'(NM - 1);
        end else if (!granted) begin
            if (pick_vld) begin
                state <= ST_GRANT;
                g     <= pick;
                gi    <= pick_idx;
            end
        end else if (release_g) begin
            state   <= ST_IDLE;
            g       <= '0;
            last_gi <= gi;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            outstanding <= '0;
        end else if (!granted || release_g) begin
            outstanding <= '0;
        end else if (accept && !s_resp) begin
            outstanding <= outstanding + 1'b1;
        end else if (!accept && s_resp && outstanding != '0) begin
            outstanding <= outstanding - 1'b1;
        end
    end

`ifdef WB_ARB_TIMEOUT_EN
    logic [CW-1:0] wd;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            wd <= '0;
        end else if (!granted || outstanding == '0 || s_resp || timeout_hit) begin
            wd <= '0;
        end else begin
            wd <= wd + 1'b1;
        end
    end

    assign timeout_hit = granted && (outstanding != '0) && !s_resp && (wd == CW'(TIMEOUT - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    // Slave side is zero outside a grant; STB also drops with CYC on an abort.
    assign o_s_cyc  = granted & i_m_cyc[gi] & ~timeout_hit;
    assign o_s_stb  = granted & i_m_stb[gi] & ~timeout_hit;
    assign o_s_we   = granted & i_m_we[gi];
    assign o_s_addr = granted ? i_m_addr[gi*AW +: AW] : '0;
    assign o_s_data = granted ? i_m_data[gi*DW +: DW] : '0;
    assign o_s_sel  = granted ? i_m_sel[gi*SW +: SW] : '0;

    assign o_m_stall = ~({NM{granted}} & g) | {NM{i_s_stall}};
    assign o_m_ack   = g & {NM{i_s_ack}};
    assign o_m_err   = g & {NM{i_s_err | timeout_hit}};
    assign o_m_data  = i_s_data;

endmodule

// File: tb/tb_wb_bram_arbiter.sv
// Directed bench for wb_bram_arbiter with a small pipelined BRAM slave model.
// Covers the WB_ARB_TIMEOUT_EN build as well when that macro is defined.
module tb_wb_bram_arbiter;

    localparam int NM      = 2;
    localparam int AW      = 8;
    localparam int DW      = 8;
    localparam int TIMEOUT = 8;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [1:0]  m_cyc, m_stb, m_we, m_sel;
    logic [15:0] m_addr, m_data;
    logic [1:0]  m_stall, m_ack, m_err;
    logic [7:0]  m_rdata;
    logic        s_cyc, s_stb, s_we;
    logic [7:0]  s_addr, s_wdata;
    logic [0:0]  s_sel;
    logic        s_stall;
    logic        s_ack;
    logic        s_err = 1'b0;
    logic [7:0]  s_rdata;

    int n_cmp = 0;
    int n_err = 0;

    wb_bram_arbiter #(.NM(NM), .AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
        .i_clk     (clk),
        .i_reset_n (rst_n),
        .i_m_cyc   (m_cyc),
        .i_m_stb   (m_stb),
        .i_m_we    (m_we),
        .i_m_addr  (m_addr),
        .i_m_data  (m_data),
        .i_m_sel   (m_sel),
        .o_m_stall (m_stall),
        .o_m_ack   (m_ack),
        .o_m_err   (m_err),
        .o_m_data  (m_rdata),
        .o_s_cyc   (s_cyc),
        .o_s_stb   (s_stb),
        .o_s_we    (s_we),
        .o_s_addr  (s_addr),
        .o_s_data  (s_wdata),
        .o_s_sel   (s_sel),
        .i_s_stall (s_stall),
        .i_s_ack   (s_ack),
        .i_s_err   (s_err),
        .i_s_data  (s_rdata)
    );

    // BRAM slave: ack and read data appear lat cycles after an accepted beat.
    logic [7:0] mem [256];
    logic [3:0] apipe = '0;
    logic [7:0] dpipe [4];
    int         lat = 1;
    logic       ack_en = 1'b1;
    logic       acc;

    assign acc     = s_cyc & s_stb & ~s_stall;
    assign s_ack   = ack_en & apipe[lat-1];
    assign s_rdata = dpipe[lat-1];

    always @(posedge clk) begin
        apipe    <= {apipe[2:0], acc};
        dpipe[0] <= mem[s_addr];
        dpipe[1] <= dpipe[0];
        dpipe[2] <= dpipe[1];
        dpipe[3] <= dpipe[2];
        if (acc && s_we) mem[s_addr] <= s_wdata;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_grant(input int m);
        int n = 0;
        #1;
        while (m_stall == 2'b11 && n < 8) begin
            tick();
            #1;
            n++;
        end
        chk("grant", {30'd0, m_stall}, (m == 1) ? 32'd1 : 32'd2);
    endtask

    task automatic do_burst(input int m, input logic [7:0] base, input int n,
                            input int st_from, input int st_len);
        int beat  = 0;
        int acks  = 0;
        int cyc_i = 0;
        m_stb[m]          = 1'b1;
        m_we[m]           = 1'b1;
        m_addr[m*8 +: 8]  = base;
        m_data[m*8 +: 8]  = base ^ 8'h5A;
        while ((beat < n || acks < n) && cyc_i < 40) begin
            s_stall = (cyc_i >= st_from) && (cyc_i < st_from + st_len);
            #1;
            if (s_stall) chk("stall_prop", {31'd0, m_stall[m]}, 32'd1);
            if (m_stb[m] && !m_stall[m]) begin
                chk("beat_addr", {24'd0, s_addr}, {24'd0, base + 8'(beat)});
                beat++;
            end
            if (m_ack[m]) acks++;
            chk("other_ack", {31'd0, m_ack[1-m]}, 32'd0);
            tick();
            cyc_i++;
            if (beat < n) begin
                m_addr[m*8 +: 8] = base + 8'(beat);
                m_data[m*8 +: 8] = (base + 8'(beat)) ^ 8'h5A;
            end else begin
                m_stb[m] = 1'b0;
            end
        end
        s_stall = 1'b0;
        chk("n_acks", acks, n);
        chk("outst_zero", {{(32-$bits(dut.outstanding)){1'b0}}, dut.outstanding}, 32'd0);
        m_cyc[m] = 1'b0;
        m_we[m]  = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        rst_n   = 1'b0;
        m_cyc   = '0;
        m_stb   = '0;
        m_we    = '0;
        m_sel   = '0;
        m_addr  = '0;
        m_data  = '0;
        s_stall = 1'b0;

        // Reset, including a reset that hits m1 mid-burst
        tick();
        tick();
        #1;
        chk("rst_s_cyc", {31'd0, s_cyc}, 32'd0);
        chk("rst_stall", {30'd0, m_stall}, 32'd3);
        chk("rst_ack", {30'd0, m_ack}, 32'd0);
        rst_n          = 1'b1;
        m_cyc          = 2'b10;
        m_stb          = 2'b10;
        m_we           = 2'b10;
        m_addr[15:8]   = 8'h33;
        tick();
        #1;
        chk("t1_m1_granted", {30'd0, m_stall}, 32'd1);
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("t1_rst_s_cyc", {31'd0, s_cyc}, 32'd0);
            chk("t1_rst_s_addr", {24'd0, s_addr}, 32'd0);
            chk("t1_rst_stall", {30'd0, m_stall}, 32'd3);
            chk("t1_rst_ack", {30'd0, m_ack}, 32'd0);
            tick();
            #1;
        end
        m_stb = 2'b00;
        m_we  = 2'b00;
        m_cyc = 2'b11;
        rst_n = 1'b1;
        tick();
        #1;
        chk("t1_first_winner", {30'd0, m_stall}, 32'd2);
        m_cyc = 2'b00;
        tick();

        // Single master write then read
        m_cyc        = 2'b01;
        m_stb        = 2'b01;
        m_we         = 2'b01;
        m_sel        = 2'b01;
        m_addr[7:0]  = 8'h10;
        m_data[7:0]  = 8'hA5;
        #1;
        chk("t2_s_cyc_pre", {31'd0, s_cyc}, 32'd0);
        tick();
        #1;
        chk("t2_s_cyc", {31'd0, s_cyc}, 32'd1);
        chk("t2_s_addr", {24'd0, s_addr}, 32'h10);
        chk("t2_s_wdata", {24'd0, s_wdata}, 32'hA5);
        chk("t2_s_we", {31'd0, s_we}, 32'd1);
        chk("t2_s_sel", {31'd0, s_sel}, 32'd1);
        chk("t2_stall", {30'd0, m_stall}, 32'd2);
        tick();
        m_we = 2'b00;
        #1;
        chk("t2_wr_ack", {30'd0, m_ack}, 32'd1);
        tick();
        m_stb = 2'b00;
        #1;
        chk("t2_rd_ack", {30'd0, m_ack}, 32'd1);
        chk("t2_rd_data", {24'd0, m_rdata}, 32'hA5);
        tick();
        #1;
        chk("t2_ack_done", {30'd0, m_ack}, 32'd0);
        chk("t2_outst", {{(32-$bits(dut.outstanding)){1'b0}}, dut.outstanding}, 32'd0);
        m_cyc = 2'b00;
        tick();

        // m1 burst with a 5-cycle slave stall after the first beat
        m_cyc = 2'b10;
        wait_grant(1);
        do_burst(1, 8'h40, 4, 1, 5);
        tick();

        // Contention: both masters keep requesting, grants must alternate 0,1,0,1
        m_cyc = 2'b11;
        for (int r = 0; r < 4; r++) begin
            wait_grant(r % 2);
            do_burst(r % 2, ((r % 2) == 1) ? 8'h60 + 8'(r*4) : 8'h20 + 8'(r*4), 4, 0, 0);
            tick();
            if (r < 2) m_cyc[r % 2] = 1'b1;
        end
        tick();

        // Early CYC drop with two beats outstanding; late acks land in IDLE
        lat   = 3;
        m_cyc = 2'b01;
        wait_grant(0);
        m_stb       = 2'b01;
        m_we        = 2'b01;
        m_addr[7:0] = 8'h70;
        tick();
        m_addr[7:0] = 8'h71;
        tick();
        m_cyc = 2'b00;
        m_stb = 2'b00;
        m_we  = 2'b00;
        #1;
        chk("t5_drop_s_cyc", {31'd0, s_cyc}, 32'd0);
        chk("t5_outst2", {{(32-$bits(dut.outstanding)){1'b0}}, dut.outstanding}, 32'd2);
        tick();
        #1;
        chk("t5_late_ack0", {30'd0, m_ack}, 32'd0);
        chk("t5_idle_stall", {30'd0, m_stall}, 32'd3);
        tick();
        m_cyc = 2'b10;
        #1;
        chk("t5_late_ack1", {30'd0, m_ack}, 32'd0);
        tick();
        #1;
        chk("t5_m1_grant", {30'd0, m_stall}, 32'd1);
        chk("t5_m1_no_ack", {30'd0, m_ack}, 32'd0);
        chk("t5_outst0", {{(32-$bits(dut.outstanding)){1'b0}}, dut.outstanding}, 32'd0);
        m_cyc = 2'b00;
        tick();
        lat = 1;
        tick();

        // Slave never acknowledges
        ack_en = 1'b0;
        m_cyc  = 2'b01;
        wait_grant(0);
        m_stb       = 2'b01;
        m_addr[7:0] = 8'h80;
        tick();
        m_stb = 2'b00;
`ifdef WB_ARB_TIMEOUT_EN
        for (int i = 1; i <= 8; i++) begin
            #1;
            chk("t6_err_pulse", {30'd0, m_err}, (i == 8) ? 32'd1 : 32'd0);
            if (i == 8) chk("t6_abort_s_cyc", {31'd0, s_cyc}, 32'd0);
            tick();
        end
        #1;
        chk("t6_idle_after_abort", {30'd0, m_stall}, 32'd3);
        chk("t6_err_cleared", {30'd0, m_err}, 32'd0);
`else
        for (int i = 0; i < 100; i++) tick();
        #1;
        chk("t6_grant_held", {30'd0, m_stall}, 32'd2);
        chk("t6_no_err", {30'd0, m_err}, 32'd0);
        chk("t6_s_cyc_held", {31'd0, s_cyc}, 32'd1);
`endif
        m_cyc = 2'b00;
        tick();
        ack_en = 1'b1;
        tick();
        #1;
        chk("end_idle_stall", {30'd0, m_stall}, 32'd3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
